fifo_ctrl: RTL
==============

Name: fifo_ctrl

Overview:
- Control end of the FIFO: owns the write and read pointers, occupancy count and status flags.
- Drives the passive FIFO memory array (memoria) through wr_enable/rd_enable/wr_ptr/rd_ptr.
- Accepts push/pop requests from the upstream producer and the downstream consumer.
- Reports full/empty, programmable almost-full/almost-empty flags and a sticky overflow/underflow error.

Parameters:
- ptr_width, 3, pointer width; FIFO depth = 2**ptr_width (8 entries, matching the memory array).
- count_width, ptr_width+1, width of occupancy count and threshold inputs (represents 0..depth).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; clears all state immediately when low.
- push  input  1  producer requests a write this cycle.
- pop  input  1  consumer requests a read this cycle.
- umbral_alto  input  count_width  almost-full threshold.
- umbral_bajo  input  count_width  almost-empty threshold.
- wr_enable  output  1  write strobe to memory.
- rd_enable  output  1  read strobe to memory.
- wr_ptr  output  ptr_width  memory write address.
- rd_ptr  output  ptr_width  memory read address.
- fifo_count  output  count_width  current occupancy.
- full  output  1  fifo_count == depth.
- empty  output  1  fifo_count == 0.
- almost_full  output  1  fifo_count >= umbral_alto.
- almost_empty  output  1  fifo_count <= umbral_bajo.
- error  output  1  sticky overflow/underflow flag.

Behaviour:
- Reset (reset low, asynchronous): wr_ptr=0, rd_ptr=0, fifo_count=0, error=0. Consequently empty=1, full=0, wr_enable=0, rd_enable=0.
- Flag outputs are combinational from registered state: full, empty, almost_full, almost_empty.
- Strobes are combinational from the current request and registered state: rd_enable = pop & ~empty; wr_enable = push & (~full | rd_enable).
- Read latency 0: the memory read is combinational, so data for rd_ptr is valid in the same cycle rd_enable is high.
- Write commits at the next rising edge.
- Pointer update: wr_ptr increments on a clock edge when wr_enable=1; rd_ptr increments when rd_enable=1.
- Pointers are modulo 2**ptr_width: 7 -> 0 wrap with no extra logic.
- Count update at the clock edge:
  - wr_enable only: +1.
  - rd_enable only: -1.
  - both or neither: unchanged.
- Full with simultaneous push and pop: both are accepted. The read returns the oldest entry and the write lands in the same slot at the edge. Count stays at depth; both pointers advance.
- Empty with simultaneous push and pop: pop is rejected, push is accepted, count becomes 1.
- Error condition: error sets at the clock edge on either of
  - overflow: push & full & ~pop.
  - underflow: pop & empty.
  - Once set, error stays high until reset; rejected requests cause no pointer or count change.
- Thresholds are sampled every cycle; changing them takes effect combinationally.
  - umbral_alto = 0 forces almost_full high.
  - umbral_bajo >= depth forces almost_empty high.
- Reset asserted mid-operation: all state clears immediately, regardless of push/pop. Memory contents are not relevant to correctness, since empty=1 blocks reads.
- Invariants (bench must assert): fifo_count == (wr_ptr - rd_ptr) mod depth, except when full (count = depth, pointers equal). full and empty are never both high.

Decomposition:
- Shared package fifo_pkg: constants FIFO_PTR_W=3, FIFO_DEPTH=8, FIFO_DATA_W=10, used by fifo_ctrl, memoria and the future top-level wrapper.
- One natural sub-module: fifo_ptr. It is a ptr_width wrap-around incrementer with enable and async active-low reset, instantiated twice (write and read side).
- Count and flag logic remain in fifo_ctrl.

Test Plan:
- Reset then idle: after reset released, no push/pop for 5 cycles -> empty=1, full=0, fifo_count=0, pointers 0, error=0, strobes 0.
- Fill: 8 consecutive pushes with umbral_alto=6 ->
  - count steps 1..8; almost_full rises when count reaches 6; full=1 after 8th edge.
  - wr_ptr wraps to 0.
  - a 9th push alone leaves wr_enable=0 and sets error=1.
- Drain and wrap: from full, 8 pops with umbral_bajo=2 ->
  - rd_enable high each cycle, rd_ptr 0..7 then 0.
  - almost_empty high once count <= 2; empty=1 at end.
  - extra pop keeps count 0 and sets error (fresh run).
- Simultaneous at full: count=8, push=pop=1 for 3 cycles -> wr_enable=rd_enable=1, count stays 8, both pointers advance 3, error=0.
- Simultaneous at empty: count=0, push=pop=1 one cycle -> rd_enable=0, wr_enable=1, count=1, error=1.
- Async reset mid-stream: count=5, assert reset between clock edges -> outputs return to reset values before the next edge; operation resumes normally after release.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO constants used by the controller, the memory array and the wrapper.
package fifo_pkg;

    localparam int FIFO_PTR_W  = 3;
    localparam int FIFO_DEPTH  = 2 ** FIFO_PTR_W;
    localparam int FIFO_DATA_W = 10;

endpackage : fifo_pkg

// File: rtl/fifo_ptr.sv
// Wrap-around pointer with enable: advances by one on each enabled rising edge.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int width = FIFO_PTR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    output logic [width-1:0] o_ptr
);

    logic [width-1:0] r_ptr;

    // NOTE: non-blocking so every register sampled at this edge sees the pre-edge state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= r_ptr + width'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule : fifo_ptr

// File: rtl/fifo_ctrl.sv
// FIFO control: read/write pointers, occupancy count, status flags and sticky error.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ptr_width   = FIFO_PTR_W,
    parameter int count_width = ptr_width + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [count_width-1:0] umbral_alto,
    input  logic [count_width-1:0] umbral_bajo,
    output logic                   wr_enable,
    output logic                   rd_enable,
    output logic [ptr_width-1:0]   wr_ptr,
    output logic [ptr_width-1:0]   rd_ptr,
    output logic [count_width-1:0] fifo_count,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   error
);

    localparam logic [count_width-1:0] DEPTH = count_width'(2 ** ptr_width);

    logic [count_width-1:0] r_count;
    logic                   r_error;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_rd_en;
    logic                   w_wr_en;
    logic                   w_overflow;
    logic                   w_underflow;

    assign w_full  = (r_count == DEPTH);
    assign w_empty = (r_count == '0);

    // A pop at full frees the slot the concurrent push writes into.
    assign w_rd_en = pop & ~w_empty;
    assign w_wr_en = push & (~w_full | w_rd_en);

    assign w_overflow  = push & w_full & ~pop;
    assign w_underflow = pop & w_empty;

    fifo_ptr #(.width(ptr_width)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_wr_en),
        .o_ptr (wr_ptr)
    );

    fifo_ptr #(.width(ptr_width)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_rd_en),
        .o_ptr (rd_ptr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_wr_en && !w_rd_en) begin
            r_count <= r_count + count_width'(1);
        end else if (!w_wr_en && w_rd_en) begin
            r_count <= r_count - count_width'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_error <= 1'b0;
        end else if (w_overflow || w_underflow) begin
            r_error <= 1'b1;
        end
    end

    assign wr_enable    = w_wr_en;
    assign rd_enable    = w_rd_en;
    assign fifo_count   = r_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= umbral_alto);
    assign almost_empty = (r_count <= umbral_bajo);
    assign error        = r_error;

endmodule : fifo_ctrl
